// File: rtl/ifu_fetch.sv
// Instruction fetch unit: boot-time program load, PC sequencing with jump/branch, halt on syscall or bad PC.
// Latency: instruction is combinational from pc (no read latency); pc updates one cycle after inputs.
// Backpressure: stall holds pc and state for the cycle; jump/branch requests are ignored while stalled.
module ifu_fetch #(
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    input  logic                          is_jump,
    input  logic                          branch_taken,
    input  logic [15:0]                   imm16,
    input  logic [25:0]                   imm26,
    input  logic                          stall,
    output logic [31:0]                   instruction,
    output logic [31:0]                   pc,
    output logic                          instr_valid,
    output logic                          halted,
    output logic                          fault
);

    localparam int          AW       = $clog2(IMEM_WORDS);
    localparam logic [31:0] SYSCALL  = 32'h0000_000C;
    // One past the last valid byte address, kept 33 bits wide so it cannot wrap.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'(IMEM_WORDS) << 2);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;

    logic [31:0] imem_q [IMEM_WORDS];
    logic [AW-1:0] imem_idx;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;
    logic        next_oor;
    logic        is_syscall;

    // Word index of the current pc relative to the start of instruction memory.
    assign imem_idx    = AW'((pc_q - RESET_PC) >> 2);
    assign instruction = imem_q[imem_idx];

    assign pc          = pc_q;
    assign instr_valid = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT);
    assign fault       = fault_q;

    // Candidate targets and next-pc selection (jump beats branch beats sequential).
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        br_target  = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        jmp_target = {pc_plus4[31:28], imm26, 2'b00};
        next_pc    = pc_plus4;
        if (is_jump) begin
            next_pc = jmp_target;
        end else if (branch_taken) begin
            next_pc = br_target;
        end
        next_oor   = (next_pc < RESET_PC) ||
                     ({1'b0, next_pc} >= PC_LIMIT) ||
                     (next_pc[1:0] != 2'b00);
        is_syscall = (instruction == SYSCALL);
    end

    // Next-state logic: boot/run/halt sequencing, pc advance, sticky fault.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        unique case (state_q)
            ST_BOOT: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    // Syscall and a bad next pc can coincide; both effects apply and pc holds.
                    if (next_oor) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                    if (is_syscall) begin
                        state_d = ST_HALT;
                    end
                    if (!next_oor && !is_syscall) begin
                        pc_d = next_pc;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, pc and fault registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Program load: only writable in BOOT, and never cleared so programs survive reset.
    always_ff @(posedge clk) begin
        if ((state_q == ST_BOOT) && load_en) begin
            imem_q[load_addr] <= load_data;
        end
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter IMEM_WORDS, default 1024: instruction-memory depth in 32-bit words, a power of two.
REQ-002 Parameter RESET_PC, default 32'h0000_3000: byte address of instruction-memory word 0 and the PC reset value.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 load_en  in  1  program-load write strobe; honoured only in state BOOT.
REQ-006 load_addr  in  log2(IMEM_WORDS)  word index for the program load.
REQ-007 load_data  in  32  instruction word to store.
REQ-008 start  in  1  moves BOOT to RUN.
REQ-009 is_jump  in  1  decoder jump indication for the current instruction.
REQ-010 branch_taken  in  1  beq resolved taken (decoder beq AND ALU zero).
REQ-011 imm16  in  16  branch offset from the decoder.
REQ-012 imm26  in  26  jump target field from the decoder.
REQ-013 stall  in  1  holds the PC for this cycle.
REQ-014 instruction  out  32  word at the current PC, presented to the decoder.
REQ-015 pc  out  32  current byte address.
REQ-016 instr_valid  out  1  instruction is meaningful this cycle.
REQ-017 halted  out  1  state is HALT.
REQ-018 fault  out  1  sticky flag: the computed next PC was out of range.

Function
REQ-019 States: BOOT, RUN, HALT. Reset enters BOOT.
REQ-020 BOOT: when load_en=1, imem[load_addr] <= load_data on the clock edge; pc holds RESET_PC; instr_valid=0.
REQ-021 BOOT to RUN on start=1; this takes priority over a load_en in the same cycle, and that load is still written.
REQ-022 instruction is combinational: imem[(pc-RESET_PC)>>2]; no read latency.
REQ-023 instr_valid=1 exactly when the state is RUN; it stays 1 during stall.
REQ-024 pc_plus4 = pc+4, computed modulo 2^32.
REQ-025 Jump target = {pc_plus4[31:28], imm26, 2'b00}.
REQ-026 Branch target = pc_plus4 + (sign-extended imm16 << 2), computed modulo 2^32.
REQ-027 Next-PC priority: is_jump, then branch_taken, then pc_plus4.
REQ-028 RUN with stall=0: pc <= next PC each cycle.
REQ-029 RUN with stall=1: pc and state hold; is_jump and branch_taken are ignored.
REQ-030 RUN to HALT when instruction == 32'h0000_000C (syscall) and stall=0; pc holds at the syscall address.
REQ-031 Out-of-range next PC: if it is below RESET_PC, at or above RESET_PC+4*IMEM_WORDS, or not word-aligned:
  - fault <= 1;
  - state <= HALT;
  - pc holds.
REQ-032 Syscall halt and out-of-range check in the same cycle: both take effect (HALT, and fault=1).
REQ-033 HALT is terminal until reset; load_en and start are ignored in HALT.
REQ-034 load_en is ignored in RUN; memory contents are never altered outside BOOT.

Reset
REQ-035 rst_n=0 asynchronously forces:
  - state BOOT;
  - pc=RESET_PC;
  - instr_valid=0, halted=0, fault=0.
REQ-036 Instruction-memory contents are not cleared by reset, so a program is retained across reset.
REQ-037 Reset asserted mid-RUN abandons the current instruction; fetch restarts only after a new start.

Verification
REQ-038 Load words 0..3 = 0x00221820, 0x00221822, 0x3C010001, 0x0000000C, then start. Required response:
  - pc sequence 0x3000, 0x3004, 0x3008, 0x300C;
  - halted=1 with pc=0x300C, fault=0.
REQ-039 At pc=0x3004, branch_taken=1 with imm16=16'hFFFF gives next pc 0x3004; with imm16=16'h0002, next pc 0x3010.
REQ-040 At pc=0x3008, is_jump=1 and branch_taken=1 with imm26=26'h0000C05: next pc 0x3014 (jump wins).
REQ-041 stall=1 for 3 cycles at pc=0x3004 (is_jump=1 during the stall): pc stays 0x3004 and instr_valid stays 1; on release, pc advances normally.
REQ-042 is_jump with imm26=0: target 0x0000_0000 is below RESET_PC, so the response is:
  - fault=1, halted=1;
  - pc unchanged.
REQ-043 rst_n pulsed low for half a cycle mid-RUN: pc returns to 0x3000 immediately and state returns to BOOT; after start, the retained program re-executes identically.
